wl_seq_ctrl: RTL

WL_SEQ_CTRL -- requirements
Module: wl_seq_ctrl

---
 rtl/wl_seq_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/wl_seq_ctrl.sv
// -----------------------------------------------------------------------------
// wl_seq_ctrl -- word-line sequencer for an SRAM-style array.
//
// Each accepted request runs the phases PRE (bit-line precharge), WLON (word
// line asserted through the 1x16 demux, write drivers enabled on writes) and
// REC (one recovery cycle that also carries the DONE pulse), then returns
// to IDLE. The only state that accepts a request is IDLE.
//
// Optional feature macro: WL_SEQ_BURST_EN
//   defined   -> adds req_len[3:0]; one request runs req_len+1 words at
//                consecutive addresses (5-bit wrap), with DONE only on the
//                last word.
//   undefined -> no req_len port; every request is a single access.
//
// All outputs come straight from flops so the demux and drivers never see
// decode glitches. The asynchronous reset clears IN/PCH/WE at once, which
// aborts an access in flight without a DONE pulse.
// -----------------------------------------------------------------------------
module wl_seq_ctrl #(
    parameter int PRE_CYC = 2,   // precharge length, 1..15
    parameter int WL_CYC  = 3    // word-line length, 1..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_addr,
    input  logic       req_wr,
`ifdef WL_SEQ_BURST_EN
    input  logic [3:0] req_len,
`endif
    output logic       pch,
    output logic       in,
    output logic       adr4,
    output logic [3:0] adr,
    output logic       we,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_WLON = 2'd2,
        ST_REC  = 2'd3
    } state_t;

    // Phase counters count down to zero, so load length-1 on phase entry.
    localparam logic [3:0] PRE_LOAD = 4'(PRE_CYC - 1);
    localparam logic [3:0] WL_LOAD  = 4'(WL_CYC - 1);

    state_t     state_r;
    logic [3:0] cnt_r;
    logic [4:0] addr_r;
    logic       wr_r;
    logic       ready_r;
    logic       pch_r;
    logic       in_r;
    logic       we_r;
    logic       done_r;
    logic       last_word_s;

`ifdef WL_SEQ_BURST_EN
    logic [3:0] len_r;   // words still to run after the current one

    // The current word is the last one once the remaining-word count is zero.
    assign last_word_s = (len_r == 4'd0);
`else
    // Without bursts every access is a single word.
    assign last_word_s = 1'b1;
`endif

    assign req_ready = ready_r;
    assign pch       = pch_r;
    assign in        = in_r;
    assign we        = we_r;
    assign done      = done_r;
    assign adr4      = addr_r[4];
    assign adr       = addr_r[3:0];

    // Sequencer FSM: state, phase counter, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= 5'd0;
            wr_r    <= 1'b0;
            ready_r <= 1'b1;
            pch_r   <= 1'b0;
            in_r    <= 1'b0;
            we_r    <= 1'b0;
            done_r  <= 1'b0;
`ifdef WL_SEQ_BURST_EN
            len_r   <= 4'd0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Handshake: capture the request so later input changes cannot leak through.
                        addr_r  <= req_addr;
                        wr_r    <= req_wr;
`ifdef WL_SEQ_BURST_EN
                        len_r   <= req_len;
`endif
                        ready_r <= 1'b0;
                        pch_r   <= 1'b1;
                        cnt_r   <= PRE_LOAD;
                        state_r <= ST_PRE;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_PRE: begin
                    if (cnt_r == 4'd0) begin
                        // Precharge off and word line on in the same edge: never overlapping.
                        pch_r   <= 1'b0;
                        in_r    <= 1'b1;
                        we_r    <= wr_r;
                        cnt_r   <= WL_LOAD;
                        state_r <= ST_WLON;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                    end
                end
                ST_WLON: begin
                    if (cnt_r == 4'd0) begin
                        in_r    <= 1'b0;
                        we_r    <= 1'b0;
                        done_r  <= last_word_s;
                        cnt_r   <= 4'd0;
                        state_r <= ST_REC;
                    end else begin
                        cnt_r   <= cnt_r - 4'd1;
                    end
                end
                ST_REC: begin
                    done_r <= 1'b0;
                    if (last_word_s) begin
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        // Next burst word: step the demux address with 5-bit wrap.
                        addr_r  <= addr_r + 5'd1;
`ifdef WL_SEQ_BURST_EN
                        len_r   <= len_r - 4'd1;
`endif
                        pch_r   <= 1'b1;
                        cnt_r   <= PRE_LOAD;
                        state_r <= ST_PRE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 4'd0;
                    ready_r <= 1'b1;
                    pch_r   <= 1'b0;
                    in_r    <= 1'b0;
                    we_r    <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
